// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU-side and memory-side bus bundle for the data cache.
//
// Handshake semantics:
//   CPU side  - cpu_req_i is the request valid; cpu_stall_o is the inverse of
//               ready. An access completes in the cycle where cpu_req_i = 1 and
//               cpu_stall_o = 0. While stalled the CPU holds req/we/addr/wdata.
//   Mem side  - mem_req_o is the request valid and is held, together with
//               mem_we_o/mem_addr_o/mem_wdata_o, until the one-cycle mem_ack_i
//               pulse (the ready). mem_rdata_i is valid only while mem_ack_i = 1.
//
// Modports: 'slave' is the cache controller view (it serves CPU requests and
// masters the memory bus); 'master' is the environment view (CPU + memory).
interface dcache_ctrl_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [255:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the
// MEM stage. 2^IDX_W lines of 8 words. Hits never stall; a miss stalls the
// pipeline while a dirty victim is written back and the line is refilled.
// Optional feature macro: DCACHE_CRITICAL_WORD_EN - serve the missing access
// directly from the refill data in the ack cycle, saving one stall cycle.
module dcache_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus,
    output logic [1:0]    dbg_state_o
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [255:0]       r_data [LINES];
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [255:0]       r_mem_wdata;
    logic [IDX_W-1:0]   r_miss_idx;
    logic [TAG_W-1:0]   r_miss_tag;

    logic [2:0]         w_word;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [255:0]       w_line;
    logic [31:0]        w_hit_word;
    logic               w_stall;
    logic [31:0]        w_rdata;
    logic               w_unused_ok;

    // Replace one 32-bit word of a line.
    function automatic logic [255:0] f_merge(input logic [255:0] line,
                                             input logic [2:0]   word,
                                             input logic [31:0]  data);
        logic [255:0] l;
        l = line;
        l[{word, 5'b0} +: 32] = data;
        return l;
    endfunction

    assign w_word      = bus.cpu_addr_i[4:2];
    assign w_idx       = bus.cpu_addr_i[5+IDX_W-1:5];
    assign w_tag       = bus.cpu_addr_i[31:5+IDX_W];
    assign w_line      = r_data[w_idx];
    assign w_hit_word  = w_line[{w_word, 5'b0} +: 32];
    assign w_hit       = bus.cpu_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    // Byte offset is ignored: accesses are word-only.
    assign w_unused_ok = ^bus.cpu_addr_i[1:0];

    // CPU-facing stall and load data; the stall must rise in the miss cycle itself.
    always_comb begin
        w_stall = 1'b0;
        w_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    if (!bus.cpu_we_i) w_rdata = w_hit_word;
                end else if (bus.cpu_req_i) begin
                    w_stall = 1'b1;
                end
            end
            S_REFILL: begin
                w_stall = 1'b1;
`ifdef DCACHE_CRITICAL_WORD_EN
                if (bus.mem_ack_i) begin
                    w_stall = 1'b0;
                    if (bus.cpu_req_i && !bus.cpu_we_i)
                        w_rdata = bus.mem_rdata_i[{w_word, 5'b0} +: 32];
                end
`endif
            end
            default: w_stall = 1'b1;
        endcase
    end

    // Controller FSM: store hits, miss detection, write-back and refill.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_miss_idx  <= '0;
            r_miss_tag  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        if (bus.cpu_we_i) begin
                            r_data[w_idx]  <= f_merge(w_line, w_word, bus.cpu_wdata_i);
                            r_dirty[w_idx] <= 1'b1;
                        end
                    end else if (bus.cpu_req_i) begin
                        // Latch the miss address so the refill completes even if the
                        // request is withdrawn.
                        r_miss_idx <= w_idx;
                        r_miss_tag <= w_tag;
                        r_mem_req  <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= S_WB;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx, 5'b0};
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= S_REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_idx, 5'b0};
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_ack_i) begin
                        r_dirty[r_miss_idx] <= 1'b0;
                        r_state             <= S_REFILL;
                        r_mem_we            <= 1'b0;
                        r_mem_addr          <= {r_miss_tag, r_miss_idx, 5'b0};
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ack_i) begin
                        r_valid[r_miss_idx] <= 1'b1;
                        r_tag[r_miss_idx]   <= r_miss_tag;
`ifdef DCACHE_CRITICAL_WORD_EN
                        if (bus.cpu_req_i && bus.cpu_we_i) begin
                            r_data[r_miss_idx]  <= f_merge(bus.mem_rdata_i, w_word, bus.cpu_wdata_i);
                            r_dirty[r_miss_idx] <= 1'b1;
                        end else begin
                            r_data[r_miss_idx]  <= bus.mem_rdata_i;
                            r_dirty[r_miss_idx] <= 1'b0;
                        end
`else
                        r_data[r_miss_idx]  <= bus.mem_rdata_i;
                        r_dirty[r_miss_idx] <= 1'b0;
`endif
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_stall_o = w_stall;
    assign bus.cpu_rdata_o = w_rdata;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;
    assign dbg_state_o     = r_state;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl with a 3-cycle-ack
// memory model, a load-data queue and a memory-transaction queue.
module tb_dcache_ctrl;
`ifdef DCACHE_CRITICAL_WORD_EN
    localparam int CW = 1;
`else
    localparam int CW = 0;
`endif
    localparam int CLEAN_STALL = 5 - CW;
    localparam int DIRTY_STALL = 9 - CW;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    logic [31:0]  exp_q[$];
    logic [32:0]  exp_mem_q[$];
    logic [255:0] backing[logic [31:0]];
    logic [31:0]  shadow[8];

    dcache_ctrl_if dif ();

    dcache_ctrl #(.IDX_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (dif),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (backing.exists(a)) return backing[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(a + 32'(4 * w));
        return l;
    endfunction

    // memory model: ack 3 cycles after each request starts
    initial begin
        int   age;
        logic prev_req;
        logic [32:0] e;
        age = 0;
        prev_req = 1'b0;
        dif.mem_ack_i   = 1'b0;
        dif.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dif.mem_req_o) begin
                if (!prev_req || dif.mem_ack_i) age = 0;
                else age++;
            end else begin
                age = 0;
            end
            prev_req        = dif.mem_req_o;
            dif.mem_ack_i   = 1'b0;
            dif.mem_rdata_i = '0;
            if (dif.mem_req_o && age == 3) begin
                dif.mem_ack_i = 1'b1;
                if (exp_mem_q.size() == 0) begin
                    check("mem_unexpected", {dif.mem_we_o, dif.mem_addr_o}, 33'h0);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_txn", {dif.mem_we_o, dif.mem_addr_o}, e);
                end
                if (dif.mem_we_o) backing[dif.mem_addr_o] = dif.mem_wdata_o;
                else dif.mem_rdata_i = line_of(dif.mem_addr_o);
            end
        end
    end

    // driver: one CPU access, counts stall cycles, pops the expected load data
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input int exp_stall);
        int   stalls;
        bit   done;
        logic [31:0] e;
        dif.cpu_req_i   = 1'b1;
        dif.cpu_we_i    = we;
        dif.cpu_addr_i  = addr;
        dif.cpu_wdata_i = wdata;
        if (!we) exp_q.push_back(exp_data);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (dif.cpu_stall_o) begin
                stalls++;
                check({tag, "_rdata_stall"}, dif.cpu_rdata_o, 32'h0);
            end else begin
                done = 1'b1;
                if (!we) begin
                    e = exp_q.pop_front();
                    check({tag, "_rdata"}, dif.cpu_rdata_o, e);
                end
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) check({tag, "_timeout"}, 1'b0, 1'b1);
        check({tag, "_stalls"}, stalls, exp_stall);
        dif.cpu_req_i = 1'b0;
        dif.cpu_we_i  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [255:0] l;
        int w;
        bit idle_seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        dif.cpu_req_i    = 1'b0;
        dif.cpu_we_i     = 1'b0;
        dif.cpu_addr_i   = '0;
        dif.cpu_wdata_i  = '0;
        wait_cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_req", dif.mem_req_o, 1'b0);
        check("rst_mem_we", dif.mem_we_o, 1'b0);
        check("rst_mem_addr", dif.mem_addr_o, 32'h0);
        check("rst_stall", dif.cpu_stall_o, 1'b0);
        check("rst_rdata", dif.cpu_rdata_o, 32'h0);
        check("rst_state", dbg_state, 2'd0);
        @(posedge clk);
        #1;

        // 1: cold load
        exp_mem_q.push_back({1'b0, 32'h0000_0040});
        access("t1_load40", 1'b0, 32'h40, 32'h0, mem_word(32'h40), CLEAN_STALL);

        // 2: hits
        access("t2_load44", 1'b0, 32'h44, 32'h0, mem_word(32'h44), 0);
        access("t2_store48", 1'b1, 32'h48, 32'hDEADBEEF, 32'h0, 0);
        access("t2_load48", 1'b0, 32'h48, 32'h0, 32'hDEADBEEF, 0);

        // 3: dirty eviction
        exp_mem_q.push_back({1'b1, 32'h0000_0040});
        exp_mem_q.push_back({1'b0, 32'h0000_0240});
        access("t3_load240", 1'b0, 32'h240, 32'h0, mem_word(32'h240), DIRTY_STALL);
        l = line_of(32'h40);
        check("t3_wb_word2", l[95:64], 32'hDEADBEEF);
        check("t3_wb_word1", l[63:32], mem_word(32'h44));
        exp_mem_q.push_back({1'b0, 32'h0000_0040});
        access("t3_reload48", 1'b0, 32'h48, 32'h0, 32'hDEADBEEF, CLEAN_STALL);

        // 4: write miss
        exp_mem_q.push_back({1'b0, 32'h0000_1000});
        access("t4_store1000", 1'b1, 32'h1000, 32'h1234_5678, 32'h0, CLEAN_STALL);
        access("t4_load1000", 1'b0, 32'h1000, 32'h0, 32'h1234_5678, 0);

        // 5: reset during the refill wait
        exp_mem_q.push_back({1'b0, 32'h0000_2060});
        dif.cpu_req_i  = 1'b1;
        dif.cpu_we_i   = 1'b0;
        dif.cpu_addr_i = 32'h2060;
        wait_cycles(2);
        check("t5_in_refill", dbg_state, 2'd2);
        void'(exp_mem_q.pop_back());
        rst_n         = 1'b0;
        dif.cpu_req_i = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_mem_req", dif.mem_req_o, 1'b0);
        check("t5_stall", dif.cpu_stall_o, 1'b0);
        check("t5_state", dbg_state, 2'd0);
        @(posedge clk);
        #1;
        exp_mem_q.push_back({1'b0, 32'h0000_2060});
        access("t5_reload2060", 1'b0, 32'h2060, 32'h0, mem_word(32'h2060), CLEAN_STALL);
        // reset dropped the dirty 0x1000 line without writing it back
        exp_mem_q.push_back({1'b0, 32'h0000_1000});
        access("t5_load1000", 1'b0, 32'h1000, 32'h0, mem_word(32'h1000), CLEAN_STALL);

        // 6: store miss whose request is withdrawn mid-refill
        exp_mem_q.push_back({1'b0, 32'h0000_3080});
        dif.cpu_req_i   = 1'b1;
        dif.cpu_we_i    = 1'b1;
        dif.cpu_addr_i  = 32'h3080;
        dif.cpu_wdata_i = 32'hCAFE_F00D;
        wait_cycles(2);
        dif.cpu_req_i = 1'b0;
        idle_seen = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (dbg_state == 2'd0) begin
                idle_seen = 1'b1;
                break;
            end
        end
        check("t6_back_idle", idle_seen, 1'b1);
        check("t6_stall", dif.cpu_stall_o, 1'b0);
        @(posedge clk);
        #1;
        dif.cpu_we_i = 1'b0;
        access("t6_load3080", 1'b0, 32'h3080, 32'h0, mem_word(32'h3080), 0);
        // clean line: replacing it needs no write-back
        exp_mem_q.push_back({1'b0, 32'h0000_3280});
        access("t6_load3280", 1'b0, 32'h3280, 32'h0, mem_word(32'h3280), CLEAN_STALL);

        // random hits on the resident 0x3280 line
        for (int i = 0; i < 8; i++) shadow[i] = mem_word(32'h3280 + 32'(4 * i));
        for (int i = 0; i < 24; i++) begin
            w = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                shadow[w] = d;
                access("rnd_store", 1'b1, 32'h3280 + 32'(4 * w), d, 32'h0, 0);
            end else begin
                access("rnd_load", 1'b0, 32'h3280 + 32'(4 * w), 32'h0, shadow[w], 0);
            end
        end

        wait_cycles(2);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_mem_q_empty", exp_mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
